// File: rtl/piano_tile_renderer_if.sv
// Pixel/key bus between the VGA timing stage and the piano tile renderer.
// The master drives pixel coordinates and keys; the slave returns colour and judging pulses.
interface piano_tile_renderer_if;
    logic [9:0]  i_x;
    logic [9:0]  i_y;
    logic        i_active;
    logic        i_vsync;
    logic [3:0]  i_key;
    logic [11:0] o_rgb;
    logic        o_active;
    logic        o_hit;
    logic        o_miss;
    logic        o_game_over;

    modport master (
        output i_x, i_y, i_active, i_vsync, i_key,
        input  o_rgb, o_active, o_hit, o_miss, o_game_over
    );

    modport slave (
        input  i_x, i_y, i_active, i_vsync, i_key,
        output o_rgb, o_active, o_hit, o_miss, o_game_over
    );
endinterface

// File: rtl/piano_tile_renderer.sv
// Piano-tiles game field: scrolls 5 rows of tiles across 4 lanes, judges key presses
// and renders registered 12-bit RGB one clock behind the VGA timing stage.
module piano_tile_renderer #(
    parameter int unsigned  SPEED     = 4,
    parameter logic [11:0]  TILE_RGB  = 12'h000,
    parameter logic [11:0]  BG_RGB    = 12'hFFF,
    parameter logic [11:0]  LINE_RGB  = 12'h888,
    parameter logic [15:0]  LFSR_SEED = 16'hACE1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    piano_tile_renderer_if.slave  bus
);
    localparam logic [7:0] STEP = 8'(SPEED);

    logic        vsync_q;
    logic [6:0]  offset_q;
    logic [4:0]  row_valid_q;
    logic [1:0]  row_lane_q [5];
    logic [15:0] lfsr_q;
    logic [11:0] rgb_q;
    logic        active_q;
    logic        hit_q;
    logic        miss_q;
    logic        game_over_q;

    logic        frame_tick;
    logic        advance;
    logic        shift;
    logic [7:0]  sum;
    logic [15:0] lfsr_next;

    assign frame_tick = vsync_q & ~bus.i_vsync;
    assign advance    = frame_tick & ~game_over_q;
    assign sum        = {1'b0, offset_q} + STEP;
    assign shift      = advance & sum[7];
    assign lfsr_next  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Judging always looks at the pre-shift hit row.
    logic [3:0] match;
    logic       hit_now;
    logic       key_miss;
    logic       clear_row4;
    logic       row4_left;
    logic       miss_now;

    assign match      = row_valid_q[4] ? (4'b0001 << row_lane_q[4]) : 4'b0000;
    assign hit_now    = |(bus.i_key & match);
    assign key_miss   = |(bus.i_key & ~match);
    assign clear_row4 = hit_now & ~game_over_q;
    assign row4_left  = row_valid_q[4] & ~clear_row4;
    assign miss_now   = key_miss | (shift & row4_left);

    logic [9:0]  yy;
    logic [2:0]  row_idx;
    logic [1:0]  pix_lane;
    logic        tile_on;
    logic [11:0] rgb_d;

    assign yy      = bus.i_y + 10'd128 - {3'b000, offset_q};
    assign row_idx = yy[9:7];

    always_comb begin
        if (bus.i_x < 10'd160)      pix_lane = 2'd0;
        else if (bus.i_x < 10'd320) pix_lane = 2'd1;
        else if (bus.i_x < 10'd480) pix_lane = 2'd2;
        else                        pix_lane = 2'd3;
    end

    always_comb begin
        tile_on = 1'b0;
        case (row_idx)
            3'd0:    tile_on = row_valid_q[0] && (row_lane_q[0] == pix_lane);
            3'd1:    tile_on = row_valid_q[1] && (row_lane_q[1] == pix_lane);
            3'd2:    tile_on = row_valid_q[2] && (row_lane_q[2] == pix_lane);
            3'd3:    tile_on = row_valid_q[3] && (row_lane_q[3] == pix_lane);
            3'd4:    tile_on = row_valid_q[4] && (row_lane_q[4] == pix_lane);
            default: tile_on = 1'b0;
        endcase
    end

    always_comb begin
        rgb_d = BG_RGB;
        if (!bus.i_active) begin
            rgb_d = 12'h000;
        end else if (bus.i_x == 10'd159 || bus.i_x == 10'd319 || bus.i_x == 10'd479) begin
            rgb_d = LINE_RGB;
        end else if (tile_on) begin
            rgb_d = TILE_RGB;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vsync_q     <= 1'b1;
            offset_q    <= '0;
            row_valid_q <= '0;
            for (int k = 0; k < 5; k++) row_lane_q[k] <= 2'd0;
            lfsr_q      <= LFSR_SEED;
            rgb_q       <= '0;
            active_q    <= 1'b0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            vsync_q  <= bus.i_vsync;
            rgb_q    <= rgb_d;
            active_q <= bus.i_active;
            hit_q    <= hit_now;
            miss_q   <= miss_now;
            if (miss_now) game_over_q <= 1'b1;
            if (advance) offset_q <= sum[6:0];
            if (shift) begin
                for (int k = 4; k > 0; k--) begin
                    row_valid_q[k] <= row_valid_q[k-1];
                    row_lane_q[k]  <= row_lane_q[k-1];
                end
                row_valid_q[0] <= 1'b1;
                row_lane_q[0]  <= lfsr_q[1:0];
                lfsr_q         <= lfsr_next;
            end else if (clear_row4) begin
                row_valid_q[4] <= 1'b0;
            end
        end
    end

    assign bus.o_rgb       = rgb_q;
    assign bus.o_active    = active_q;
    assign bus.o_hit       = hit_q;
    assign bus.o_miss      = miss_q;
    assign bus.o_game_over = game_over_q;
endmodule

// File: tb/tb_piano_tile_renderer.sv
// Randomized bench for piano_tile_renderer against a frame-level model of the game field.
module tb_piano_tile_renderer;
    localparam int          SPEED     = 4;
    localparam logic [11:0] TILE_RGB  = 12'h000;
    localparam logic [11:0] BG_RGB    = 12'hFFF;
    localparam logic [11:0] LINE_RGB  = 12'h888;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    piano_tile_renderer_if vif ();

    piano_tile_renderer #(
        .SPEED     (SPEED),
        .TILE_RGB  (TILE_RGB),
        .BG_RGB    (BG_RGB),
        .LINE_RGB  (LINE_RGB),
        .LFSR_SEED (LFSR_SEED)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (vif)
    );

    // Reference field: offset within a 128-pixel row, rows 0..4, lane per row.
    int        m_off;
    bit        m_v [5];
    int        m_l [5];
    bit [15:0] m_lfsr;
    bit        m_vq;
    bit        m_go;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pixel(input int x, input int y, input bit act);
        int idx;
        int ln;
        if (!act) return 0;
        if (x == 159 || x == 319 || x == 479) return int'(LINE_RGB);
        idx = (y + 128 - m_off) / 128;
        ln  = (x >= 480) ? 3 : x / 160;
        if (idx <= 4 && m_v[idx] && m_l[idx] == ln) return int'(TILE_RGB);
        return int'(BG_RGB);
    endfunction

    function automatic logic [3:0] correct_key();
        logic [3:0] k;
        k = 4'b0000;
        if (m_v[4]) k[m_l[4]] = 1'b1;
        return k;
    endfunction

    task automatic cycle(input bit r, input int x, input int y, input bit act, input bit vs,
                         input logic [3:0] key);
        int  e_rgb;
        bit  e_hit;
        bit  e_miss;
        bit  tick;
        bit  shift;
        bit  v4_after;
        rst          = r;
        vif.i_x      = 10'(x);
        vif.i_y      = 10'(y);
        vif.i_active = act;
        vif.i_vsync  = vs;
        vif.i_key    = key;
        @(posedge clk);
        #1;
        if (r) begin
            m_off  = 0;
            m_lfsr = LFSR_SEED;
            m_vq   = 1'b1;
            m_go   = 1'b0;
            for (int k = 0; k < 5; k++) begin
                m_v[k] = 1'b0;
                m_l[k] = 0;
            end
            e_rgb  = 0;
            e_hit  = 1'b0;
            e_miss = 1'b0;
            act    = 1'b0;
        end else begin
            e_rgb  = model_pixel(x, y, act);
            e_hit  = 1'b0;
            e_miss = 1'b0;
            tick   = m_vq && !vs;
            m_vq   = vs;
            for (int l = 0; l < 4; l++) begin
                if (key[l]) begin
                    if (m_v[4] && m_l[4] == l) e_hit = 1'b1;
                    else e_miss = 1'b1;
                end
            end
            v4_after = m_v[4] && !(e_hit && !m_go);
            shift    = tick && !m_go && (m_off + SPEED >= 128);
            if (tick && !m_go) m_off = (m_off + SPEED) % 128;
            if (shift) begin
                if (v4_after) e_miss = 1'b1;
                for (int k = 4; k > 0; k--) begin
                    m_v[k] = m_v[k-1];
                    m_l[k] = m_l[k-1];
                end
                m_v[0] = 1'b1;
                m_l[0] = int'(m_lfsr[1:0]);
                m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            end else begin
                m_v[4] = v4_after;
            end
            if (e_miss) m_go = 1'b1;
        end
        check_eq("rgb", int'(vif.o_rgb), e_rgb);
        check_eq("active", int'(vif.o_active), int'(act));
        check_eq("hit", int'(vif.o_hit), int'(e_hit));
        check_eq("miss", int'(vif.o_miss), int'(e_miss));
        check_eq("game_over", int'(vif.o_game_over), int'(m_go));
    endtask

    task automatic rand_cycle(input bit vs, input logic [3:0] key);
        cycle(1'b0, int'($urandom_range(639)), int'($urandom_range(479)),
              $urandom_range(7) != 0, vs, key);
    endtask

    // One frame: tick cycle followed by three active-area cycles.
    task automatic frame(input bit hit_tick, input bit hit_late, input bit rnd_keys);
        logic [3:0] k;
        k = hit_tick ? correct_key() : 4'b0000;
        if (rnd_keys) k = 4'($urandom_range(15));
        rand_cycle(1'b0, k);
        for (int i = 0; i < 3; i++) begin
            k = (i == 0 && hit_late) ? correct_key() : 4'b0000;
            if (rnd_keys && i == 0) k = 4'($urandom_range(15));
            rand_cycle(1'b1, k);
        end
    endtask

    task automatic play_frame();
        bit will_shift;
        will_shift = !m_go && (m_off + SPEED >= 128);
        if (m_v[4] && will_shift) frame(1'b1, 1'b0, 1'b0);
        else frame(1'b0, m_v[4] && $urandom_range(3) == 0, 1'b0);
    endtask

    initial begin
        int guard;
        rst          = 1'b1;
        vif.i_x      = '0;
        vif.i_y      = '0;
        vif.i_active = 1'b0;
        vif.i_vsync  = 1'b1;
        vif.i_key    = '0;

        cycle(1'b1, 0, 0, 1'b1, 1'b1, 4'b0000);
        cycle(1'b1, 100, 100, 1'b1, 1'b1, 4'b0000);

        // Two full scroll periods: first tile enters, then moves into the visible row 1.
        for (int f = 0; f < 64; f++) frame(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 200, 10, 1'b1, 1'b1, 4'b0000);
        check_eq("px_tile", int'(vif.o_rgb), int'(TILE_RGB));
        cycle(1'b0, 159, 10, 1'b1, 1'b1, 4'b0000);
        check_eq("px_line", int'(vif.o_rgb), int'(LINE_RGB));
        cycle(1'b0, 10, 10, 1'b1, 1'b1, 4'b0000);
        check_eq("px_bg", int'(vif.o_rgb), int'(BG_RGB));
        cycle(1'b0, 200, 10, 1'b0, 1'b1, 4'b0000);
        check_eq("px_blank", int'(vif.o_rgb), 0);

        // Play correctly: tiles are hit either mid-period or on the shifting tick.
        for (int f = 0; f < 260; f++) play_frame();
        check_eq("no_game_over", int'(vif.o_game_over), 0);

        // Wrong key on a live hit-row tile.
        guard = 0;
        while (!m_v[4] && guard < 200) begin
            play_frame();
            guard++;
        end
        check_eq("row4_ready", int'(m_v[4]), 1);
        cycle(1'b0, 300, 300, 1'b1, 1'b1, correct_key() ^ 4'b0001 ^ (correct_key() << 1));
        check_eq("wrong_key_go", int'(vif.o_game_over), 1);

        // Field frozen after game over while keys keep being judged.
        for (int f = 0; f < 40; f++) frame(1'b0, 1'b0, 1'b1);

        // Mid-frame reset from game over.
        rand_cycle(1'b1, 4'b0000);
        cycle(1'b1, 250, 250, 1'b1, 1'b1, 4'b0000);

        // No keys: first tile reaching the hit row escapes.
        guard = 0;
        while (!m_go && guard < 400) begin
            frame(1'b0, 1'b0, 1'b0);
            guard++;
        end
        check_eq("escape_go", int'(vif.o_game_over), 1);
        for (int f = 0; f < 8; f++) frame(1'b0, 1'b0, 1'b0);

        cycle(1'b1, 0, 0, 1'b1, 1'b1, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
